// File: rtl/instr_stream_loader_if.sv
// Interface bundling the loader's control, byte-stream and instruction-memory
// write signals.
// master: driver side (boot controller / UART RX / observer).
// slave: the loader itself.
interface instr_stream_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic                  load_done;
  logic                  load_err;
  logic                  cpu_run;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
           word_cnt, load_done, load_err, cpu_run
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata,
           word_cnt, load_done, load_err, cpu_run
  );
endinterface

// File: rtl/instr_stream_loader.sv
// Boot-time program loader.
// Takes a byte stream made of a 4-byte little-endian word count N followed by
// N little-endian instruction words. It writes each word into instruction
// memory and releases the core (cpu_run) once the whole image has landed.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte, checked
// in state S_CHK.
module instr_stream_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_stream_loader_if.slave bus
);

  localparam logic [32:0]         DEPTH   = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t                state;
  logic [1:0]            lane;
  logic [23:0]           word_buf;
  logic [ADDR_WIDTH:0]   words_total;
  logic [ADDR_WIDTH:0]   words_rx;
  logic [7:0]            chk;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic                  load_done;
  logic                  load_err;
  logic                  cpu_run;
  logic                  ready;

  // Byte acceptance depends on state only, so the sender never sees it
  // change with its own valid.
  always_comb begin
    ready = 1'b0;
    if (state == S_LEN || state == S_DATA) ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    if (state == S_CHK) ready = 1'b1;
`endif
  end

  wire                        xfer       = bus.byte_valid && ready;
  wire                        last_lane  = (lane == 2'd3);
  wire [31:0]                 word       = {bus.byte_data, word_buf};
  wire [ADDR_WIDTH:0]         words_next = words_rx + CNT_ONE;

  // Where the session goes once the payload (or an empty header) is complete.
`ifdef LOADER_CHECKSUM_EN
  wire state_t payload_end = S_CHK;
`else
  wire state_t payload_end = S_DONE;
`endif

  // Session FSM plus byte assembly, memory write strobe and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      lane        <= 2'd0;
      word_buf    <= '0;
      words_total <= '0;
      words_rx    <= '0;
      chk         <= 8'h00;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      word_cnt    <= '0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      cpu_run     <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we) word_cnt <= word_cnt + CNT_ONE;

      if (xfer) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0:    word_buf[7:0]   <= bus.byte_data;
          2'd1:    word_buf[15:8]  <= bus.byte_data;
          2'd2:    word_buf[23:16] <= bus.byte_data;
          default: ;
        endcase
      end

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (state == S_DONE) begin
            load_done <= 1'b1;
            cpu_run   <= 1'b1;
          end
          if (state == S_ERR) load_err <= 1'b1;
          if (bus.start) begin
            state     <= S_LEN;
            word_cnt  <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_run   <= 1'b0;
            lane      <= 2'd0;
            words_rx  <= '0;
            chk       <= 8'h00;
          end
        end
        S_LEN: begin
          if (xfer && last_lane) begin
            if ({1'b0, word} > DEPTH) begin
              state <= S_ERR;
            end else if (word == 32'd0) begin
              state <= payload_end;
            end else begin
              words_total <= word[ADDR_WIDTH:0];
              state       <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            chk <= chk ^ bus.byte_data;
            if (last_lane) begin
              imem_we    <= 1'b1;
              imem_addr  <= words_rx[ADDR_WIDTH-1:0];
              imem_wdata <= word;
              words_rx   <= words_next;
              if (words_next == words_total) state <= payload_end;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) state <= (bus.byte_data == chk) ? S_DONE : S_ERR;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready = ready;
  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = imem_addr;
  assign bus.imem_wdata = imem_wdata;
  assign bus.word_cnt   = word_cnt;
  assign bus.load_done  = load_done;
  assign bus.load_err   = load_err;
  assign bus.cpu_run    = cpu_run;

endmodule
